program_loader: RTL and testbench
=================================

// Module: program_loader
// PURPOSE
//  Boot sequencer for program_ram. Receives a framed byte stream from the UART receiver,
//  packs bytes into 32-bit little-endian words and drives the brx_* write port of
//  program_ram (imem and dmem copies written together). Holds the CPU in reset while
//  loading; releases it only after a complete, valid image has been written.
// PARAMETERS
//  BASE_ADDR       32'h0     byte address of first word written; must be word-aligned
//  MAX_WORDS       16384     image length limit in words (program_ram depth)
//  TIMEOUT_CYCLES  1000000   max idle clocks between bytes inside a frame
//  HOLD_ON_BOOT    1         1: cpu_rst_out=1 out of reset; 0: cpu_rst_out=0 out of reset
// PORTS
//  clk_in               in   1   system clock
//  rst_n_in             in   1   asynchronous active-low reset
//  rx_valid_in          in   1   one-cycle strobe, rx_data_in valid; no backpressure
//  rx_data_in           in   8   received byte
//  brx_addr_out         out  32  program_ram write byte address
//  brx_data_out         out  32  program_ram write data
//  brx_valid_out        out  1   program_ram write strobe, one cycle per word
//  cpu_rst_out          out  1   active-high CPU/pipeline reset
//  busy_out             out  1   1 while a frame is in progress
//  done_out             out  1   1 after successful load until next frame starts
//  error_out            out  1   1 after failed load until next frame starts
//  words_written_out    out  15  words written in current/last frame
// BEHAVIOUR
//  - Frame: sync byte 8'hA5, 4-byte word count N (LSB first), N*4 data bytes (each word
//    LSB first), then [PROGRAM_LOADER_CHECKSUM_EN only] 4-byte checksum (LSB first).
//  - Reset (async, rst_n_in=0): state IDLE; brx_* = 0; busy/done/error = 0;
//    words_written_out = 0; cpu_rst_out = HOLD_ON_BOOT; byte/word/timeout counters = 0.
//  - States: IDLE, LEN, DATA, CSUM, DONE, ERROR.
//  - IDLE/DONE/ERROR: rx byte 8'hA5 -> LEN, busy=1, done=0, error=0, cpu_rst_out=1,
//    words_written=0. Other bytes ignored. cpu_rst_out asserts the cycle after the sync byte.
//  - LEN: after 4th byte: N==0 -> DONE (or CSUM when macro on); N>MAX_WORDS -> ERROR;
//    else DATA.
//  - DATA: 4th byte of a word -> next cycle brx_valid_out=1, brx_data_out=packed word,
//    brx_addr_out=BASE_ADDR+4*idx (idx from 0), words_written increments same cycle.
//    Latency: one clock from accepting 4th byte to strobe. brx_addr/data hold last value
//    when strobe low. After word N-1 is written -> DONE (or CSUM).
//  - DONE: busy=0, done=1, cpu_rst_out=0 one cycle after entry.
//  - ERROR: busy=0, error=1, cpu_rst_out stays 1 (partial image never executes).
//  - Timeout: in LEN/DATA/CSUM, counter clears on each rx_valid_in, increments otherwise;
//    reaching TIMEOUT_CYCLES -> ERROR. Not counted in IDLE/DONE/ERROR.
//  - Byte 8'hA5 inside LEN/DATA/CSUM is ordinary payload, never a resync.
//  - rx_valid_in on the same cycle as a timeout: timeout wins, byte dropped.
//  - Reset mid-frame: abort immediately; no further strobes; partial RAM contents kept.
//  - Address arithmetic modulo 2^32; N is 32 bits, compared unsigned against MAX_WORDS.
// CONFIGURATION
//  PROGRAM_LOADER_CHECKSUM_EN defined: after data, CSUM collects 4 bytes; compared with
//   32-bit wrapping sum of all N data words: match -> DONE, mismatch -> ERROR.
//   N==0 expects checksum 32'h0.
//  Not defined: no CSUM state; last data word -> DONE; no checksum bytes expected.
// TESTING
//  1. Reset, HOLD_ON_BOOT=1 -> cpu_rst_out=1, busy/done/error=0, brx_valid_out=0.
//  2. A5, 02 00 00 00, 78 56 34 12, EF BE AD DE -> strobes addr 0 data 32'h12345678,
//     addr 4 data 32'hDEADBEEF; done_out=1, cpu_rst_out=0, words_written_out=2.
//  3. A5, 00 40 00 00 then A5, 01 40 00 00 (N=16385) -> first header accepted;
//     second -> error_out=1, zero strobes, cpu_rst_out=1.
//  4. A5, 01 00 00 00, 11 22, then silence TIMEOUT_CYCLES clocks -> error_out=1,
//     no strobe; then full valid frame -> done_out=1.
//  5. Macro on: A5, 01 00 00 00, 01 00 00 00, checksum 01 00 00 00 -> done; same frame
//     with checksum 02 00 00 00 -> error, cpu_rst_out=1.
//  6. rst_n_in low during DATA after 1 of 3 words -> outputs at reset values at once;
//     following valid frame loads normally from BASE_ADDR.

Source files
------------

// File: rtl/program_loader.sv
// Boot loader: unpacks a framed UART byte stream into 32-bit words for program_ram and gates CPU reset.
// Optional checksum trailer enabled by defining PROGRAM_LOADER_CHECKSUM_EN.
module program_loader #(
    parameter logic [31:0] BASE_ADDR      = 32'h0,
    parameter int unsigned MAX_WORDS      = 16384,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned HOLD_ON_BOOT   = 1
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        rx_valid_in,
    input  logic [7:0]  rx_data_in,
    output logic [31:0] brx_addr_out,
    output logic [31:0] brx_data_out,
    output logic        brx_valid_out,
    output logic        cpu_rst_out,
    output logic        busy_out,
    output logic        done_out,
    output logic        error_out,
    output logic [14:0] words_written_out
);

    localparam logic [7:0]    SYNC_BYTE = 8'hA5;
    localparam int unsigned   TW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERROR
    } state_t;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    localparam state_t S_POST_DATA = S_CSUM;
`else
    localparam state_t S_POST_DATA = S_DONE;
`endif

    state_t        state_q, state_d;
    logic [1:0]    byte_cnt_q, byte_cnt_d;
    logic [23:0]   shift_q, shift_d;
    logic [31:0]   len_q, len_d;
    logic [TW-1:0] to_q, to_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   data_q, data_d;
    logic          valid_q, valid_d;
    logic          cpu_rst_q, cpu_rst_d;
    logic [14:0]   ww_q, ww_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [31:0]   csum_q, csum_d;
`endif

    logic [31:0] word_w;
    logic        last_byte;
    logic        active;
    logic        timeout_hit;

    // Bytes arrive LSB first, so the newest byte lands in the top of the word.
    assign word_w      = {rx_data_in, shift_q};
    assign last_byte   = (byte_cnt_q == 2'd3);
    assign active      = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CSUM);
    // Independent of rx_valid_in so a byte coinciding with expiry is dropped.
    assign timeout_hit = active && (to_q == TO_LAST);

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        len_d      = len_q;
        to_d       = to_q;
        addr_d     = addr_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        cpu_rst_d  = cpu_rst_q;
        ww_d       = ww_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        csum_d     = csum_q;
`endif

        if (active) begin
            to_d = rx_valid_in ? '0 : to_q + 1'b1;
        end

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (state_q == S_DONE) begin
                    cpu_rst_d = 1'b0;
                end
                if (rx_valid_in && (rx_data_in == SYNC_BYTE)) begin
                    state_d    = S_LEN;
                    byte_cnt_d = '0;
                    cpu_rst_d  = 1'b1;
                    ww_d       = '0;
                    to_d       = '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    csum_d     = '0;
`endif
                end
            end

            S_LEN: begin
                if (timeout_hit) begin
                    state_d = S_ERROR;
                end else if (rx_valid_in) begin
                    shift_d    = word_w[31:8];
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (last_byte) begin
                        len_d = word_w;
                        if (word_w == 32'd0) begin
                            state_d = S_POST_DATA;
                        end else if (word_w > 32'(MAX_WORDS)) begin
                            state_d = S_ERROR;
                        end else begin
                            state_d = S_DATA;
                        end
                    end
                end
            end

            S_DATA: begin
                if (timeout_hit) begin
                    state_d = S_ERROR;
                end else if (rx_valid_in) begin
                    shift_d    = word_w[31:8];
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (last_byte) begin
                        valid_d = 1'b1;
                        data_d  = word_w;
                        addr_d  = BASE_ADDR + {15'd0, ww_q, 2'b00};
                        ww_d    = ww_q + 15'd1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        csum_d  = csum_q + word_w;
`endif
                        if (({17'd0, ww_q} + 32'd1) == len_q) begin
                            state_d = S_POST_DATA;
                        end
                    end
                end
            end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (timeout_hit) begin
                    state_d = S_ERROR;
                end else if (rx_valid_in) begin
                    shift_d    = word_w[31:8];
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (last_byte) begin
                        state_d = (word_w == csum_q) ? S_DONE : S_ERROR;
                    end
                end
            end
`endif

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q    <= S_IDLE;
            byte_cnt_q <= '0;
            shift_q    <= '0;
            len_q      <= '0;
            to_q       <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            cpu_rst_q  <= (HOLD_ON_BOOT != 0);
            ww_q       <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
            len_q      <= len_d;
            to_q       <= to_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            cpu_rst_q  <= cpu_rst_d;
            ww_q       <= ww_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    assign brx_addr_out      = addr_q;
    assign brx_data_out      = data_q;
    assign brx_valid_out     = valid_q;
    assign cpu_rst_out       = cpu_rst_q;
    assign busy_out          = active;
    assign done_out          = (state_q == S_DONE);
    assign error_out         = (state_q == S_ERROR);
    assign words_written_out = ww_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: a frame-level model predicts write strobes and final status.
module tb_program_loader;

    localparam int unsigned TO   = 20;
    localparam int unsigned MAXW = 16384;
    localparam logic [31:0] BASE = 32'h0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic [31:0] brx_addr_out;
    logic [31:0] brx_data_out;
    logic        brx_valid_out;
    logic        cpu_rst_out;
    logic        busy_out;
    logic        done_out;
    logic        error_out;
    logic [14:0] words_written_out;

    program_loader #(
        .BASE_ADDR     (BASE),
        .MAX_WORDS     (MAXW),
        .TIMEOUT_CYCLES(TO),
        .HOLD_ON_BOOT  (1)
    ) dut (
        .clk_in           (clk),
        .rst_n_in         (rst_n),
        .rx_valid_in      (rx_valid),
        .rx_data_in       (rx_data),
        .brx_addr_out     (brx_addr_out),
        .brx_data_out     (brx_data_out),
        .brx_valid_out    (brx_valid_out),
        .cpu_rst_out      (cpu_rst_out),
        .busy_out         (busy_out),
        .done_out         (done_out),
        .error_out        (error_out),
        .words_written_out(words_written_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          ww;
    } strobe_t;

    int          total = 0;
    int          bad   = 0;
    strobe_t     exp_q[$];
    strobe_t     cur_s;
    logic [31:0] fw[$];
    logic [31:0] last_addr = '0;
    logic [31:0] last_data = '0;
    int          strobes_seen = 0;
    int          seen_before;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic check_status(input string tag, input bit b, input bit d, input bit e,
                                input bit c, input int ww);
        check({tag, "_busy"},    32'(busy_out),          32'(b));
        check({tag, "_done"},    32'(done_out),          32'(d));
        check({tag, "_error"},   32'(error_out),         32'(e));
        check({tag, "_cpu_rst"}, 32'(cpu_rst_out),       32'(c));
        check({tag, "_ww"},      32'(words_written_out), 32'(ww));
    endtask

    task automatic check_reset_values(input string tag);
        check_status(tag, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        check({tag, "_valid"}, 32'(brx_valid_out), 32'd0);
        check({tag, "_addr"},  brx_addr_out,       32'd0);
        check({tag, "_data"},  brx_data_out,       32'd0);
    endtask

    // Called at a falling edge; the byte is taken on the following rising edge.
    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Sends sync, length n, the first nsent words of fw and (if enabled) the checksum
    // offset by csum_delta; predicts strobes and, for complete frames, the final status.
    task automatic send_frame(input string tag, input logic [31:0] n, input int nsent,
                              input logic [31:0] csum_delta);
        bit          hdr_ok;
        bit          err;
        logic [31:0] sum;
        hdr_ok = (n <= 32'(MAXW));
        sum    = '0;
        if (hdr_ok)
            for (int i = 0; i < nsent; i++)
                exp_q.push_back('{addr: BASE + 32'(i) * 32'd4, data: fw[i], ww: i + 1});
        send_byte(8'hA5);
        send_word(n);
        for (int i = 0; i < nsent; i++) begin
            send_word(fw[i]);
            sum = sum + fw[i];
        end
        err = !hdr_ok;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        if (hdr_ok && nsent == int'(n)) send_word(sum + csum_delta);
        err = err || (csum_delta != 32'd0);
`endif
        if (!hdr_ok || nsent == int'(n)) begin
            idle(2);
            check_status(tag, 1'b0, !err, err, err, hdr_ok ? int'(n) : 0);
            check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (rst_n && brx_valid_out) begin
            strobes_seen++;
            last_addr = brx_addr_out;
            last_data = brx_data_out;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_strobe: got addr=%h data=%h want no strobe",
                         brx_addr_out, brx_data_out);
            end else begin
                cur_s = exp_q.pop_front();
                check("strobe_addr", brx_addr_out, cur_s.addr);
                check("strobe_data", brx_data_out, cur_s.data);
                check("strobe_ww", 32'(words_written_out), 32'(cur_s.ww));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

    initial begin
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = '0;
        repeat (3) @(negedge clk);
        check_reset_values("rst_hold");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_values("rst_rel");

        // Two-word image.
        fw = '{32'h12345678, 32'hDEADBEEF};
        send_frame("t2", 32'd2, 2, 32'd0);
        check("t2_last_addr", last_addr, 32'h0000_0004);
        check("t2_last_data", last_data, 32'hDEADBEEF);
        check("t2_strobes", 32'(strobes_seen), 32'd2);

        // Largest legal header, then silence until the timeout.
        seen_before = strobes_seen;
        send_byte(8'hA5);
        check_status("t3_sync", 1'b1, 1'b0, 1'b0, 1'b1, 0);
        send_word(32'h0000_4000);
        check_status("t3_hdr", 1'b1, 1'b0, 1'b0, 1'b1, 0);
        idle(TO - 1);
        check("t3_pre_to_err", 32'(error_out), 32'd0);
        idle(1);
        check_status("t3_to", 1'b0, 1'b0, 1'b1, 1'b1, 0);
        send_frame("t3_big", 32'd16385, 0, 32'd0);
        check("t3_strobes", 32'(strobes_seen), 32'(seen_before));

        // Timeout mid-word; a byte arriving on the expiry cycle is dropped.
        send_byte(8'hA5);
        send_word(32'd1);
        send_byte(8'h11);
        send_byte(8'h22);
        idle(TO - 1);
        check_status("t4_pre_to", 1'b1, 1'b0, 1'b0, 1'b1, 0);
        send_byte(8'h33);
        check_status("t4_to", 1'b0, 1'b0, 1'b1, 1'b1, 0);
        check("t4_strobes", 32'(strobes_seen), 32'(seen_before));
        fw = '{32'hCAFEF00D};
        send_frame("t4_ok", 32'd1, 1, 32'd0);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
        fw = '{32'h0000_0001};
        send_frame("t5_good", 32'd1, 1, 32'd0);
        send_frame("t5_bad", 32'd1, 1, 32'd1);
`endif

        // Empty image.
        send_frame("t_empty", 32'd0, 0, 32'd0);

        // Reset during DATA after one of three words.
        fw = '{32'h11111111, 32'h22222222, 32'h33333333};
        send_frame("t6_part", 32'd3, 1, 32'd0);
        send_byte(8'h44);
        send_byte(8'h55);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("t6_rst");
        check("t6_pending", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        fw = '{32'hA0A0A0A0, 32'h5A5A5AA5};
        send_frame("t6_reload", 32'd2, 2, 32'd0);
        check("t6_last_addr", last_addr, 32'h0000_0004);
        check("t6_last_data", last_data, 32'h5A5A5AA5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
